// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: operation encodings and FSM state type.
package seq_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_MOD = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one step per clock for WIDTH steps.
// A single 2*WIDTH register holds {hi, lo} for MUL and {remainder, quotient} for DIV/MOD.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               active;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic               is_mul;
  logic               is_mod;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;

  assign done = active && (count == CW'(WIDTH - 1));

  // The trial difference only matters when it is non-negative, so it always fits in WIDTH bits.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    q_bit   = (shifted >= {1'b0, opnd});
    diff    = shifted[WIDTH-1:0] - opnd;
    rem_nxt = q_bit ? diff : shifted[WIDTH-1:0];
    quo_nxt = {acc[WIDTH-2:0], q_bit};
    if (is_mul) begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end else begin
      acc_nxt = {rem_nxt, quo_nxt};
    end
  end

  always_comb begin
    result = acc_nxt;
    if (!is_mul) begin
      result = is_mod ? {{WIDTH{1'b0}}, rem_nxt} : {{WIDTH{1'b0}}, quo_nxt};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_mul <= 1'b0;
      is_mod <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      count  <= '0;
      is_mul <= (op == OP_MUL);
      is_mod <= (op == OP_MOD);
      if (op == OP_MUL) begin
        acc  <= {{WIDTH{1'b0}}, b};
        opnd <= a;
      end else begin
        acc  <= {{WIDTH{1'b0}}, a};
        opnd <= b;
      end
    end else if (active) begin
      acc <= acc_nxt;
      if (done) begin
        active <= 1'b0;
        count  <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: valid/ready handshake, IDLE/BUSY/DONE control, single-cycle ops
// and the output registers; MUL and non-trivial DIV/MOD run in seq_alu_muldiv.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div0,
  output logic                 err
);

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               iter_op;
  logic               md_start;
  logic               md_done;
  logic [2*WIDTH-1:0] md_result;
  logic [2*WIDTH-1:0] quick_result;
  logic               quick_div0;
  logic               quick_err;
  logic [2*WIDTH-1:0] result_q;
  logic               div0_q;
  logic               err_q;

  assign accept   = in_valid && in_ready;
  assign iter_op  = (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && (b != '0));
  assign md_start = accept && iter_op;

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .op     (op),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = iter_op ? BUSY : DONE;
      BUSY: if (md_done) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are forced low for the whole time reset is held.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE) && !rst;
  end

  always_comb begin
    quick_result = '0;
    quick_div0   = 1'b0;
    quick_err    = 1'b0;
    case (op)
      OP_AND: quick_result = {{WIDTH{1'b0}}, a & b};
      OP_OR:  quick_result = {{WIDTH{1'b0}}, a | b};
      OP_ADD: quick_result = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
      OP_SUB: quick_result = {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
      OP_MUL: quick_result = '0;
      OP_DIV, OP_MOD: begin
        quick_result = '1;
        quick_div0   = 1'b1;
      end
      default: quick_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      div0_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      result_q <= iter_op ? '0 : quick_result;
      div0_q   <= iter_op ? 1'b0 : quick_div0;
      err_q    <= iter_op ? 1'b0 : quick_err;
    end else if (md_done) begin
      result_q <= md_result;
    end
  end

  assign result = rst ? '0 : result_q;
  assign div0   = div0_q && out_valid;
  assign err    = err_q && out_valid;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=4 with hand-computed expected values.
module tb_seq_alu;

  localparam int WIDTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   a;
  logic [3:0]   b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   result;
  logic         div0;
  logic         err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .div0      (div0),
    .err       (err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits for in_ready, presents one request, then counts cycles until out_valid.
  task automatic applyStimulus(input logic [3:0] ta, input logic [3:0] tb, input logic [2:0] top,
                               output int lat, output logic rdy_seen);
    int guard;
    guard = 0;
    rdy_seen = 1'b0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("accept_ready", {31'b0, in_ready}, 32'd1);
    a = ta;
    b = tb;
    op = top;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      rdy_seen |= in_ready;
      @(posedge clk); #1;
      lat++;
    end
    rdy_seen |= in_ready;
  endtask

  task automatic runOp(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                       input logic [2:0] top, input logic [7:0] er, input int el,
                       input logic e0, input logic ee);
    int lat;
    logic rdy_seen;
    applyStimulus(ta, tb, top, lat, rdy_seen);
    checkOutput({tag, "_res"}, {24'b0, result}, {24'b0, er});
    checkOutput({tag, "_lat"}, lat, el);
    checkOutput({tag, "_div0"}, {31'b0, div0}, {31'b0, e0});
    checkOutput({tag, "_err"}, {31'b0, err}, {31'b0, ee});
    checkOutput({tag, "_rdy_low"}, {31'b0, rdy_seen}, 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_idle"}, {28'b0, in_ready, out_valid, div0, err}, 32'b1000);
  endtask

  initial begin
    int lat;
    logic rdy_seen;
    logic ov_seen;

    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_result", {24'b0, result}, 32'd0);
    checkOutput("rst_flags", {30'b0, div0, err}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", {31'b0, in_ready}, 32'd1);

    runOp("add_9_12",  4'd9,  4'd12, 3'b010, 8'h15, 1, 1'b0, 1'b0);
    runOp("sub_3_5",   4'd3,  4'd5,  3'b011, 8'hFE, 1, 1'b0, 1'b0);
    runOp("mul_15_15", 4'd15, 4'd15, 3'b100, 8'hE1, 5, 1'b0, 1'b0);
    runOp("div_13_4",  4'd13, 4'd4,  3'b101, 8'h03, 5, 1'b0, 1'b0);
    runOp("mod_13_4",  4'd13, 4'd4,  3'b110, 8'h01, 5, 1'b0, 1'b0);
    runOp("div_13_0",  4'd13, 4'd0,  3'b101, 8'hFF, 1, 1'b1, 1'b0);
    runOp("and_12_10", 4'd12, 4'd10, 3'b000, 8'h08, 1, 1'b0, 1'b0);
    runOp("or_12_10",  4'd12, 4'd10, 3'b001, 8'h0E, 1, 1'b0, 1'b0);
    runOp("add_carry", 4'd15, 4'd15, 3'b010, 8'h1E, 1, 1'b0, 1'b0);
    runOp("sub_0_15",  4'd0,  4'd15, 3'b011, 8'hF1, 1, 1'b0, 1'b0);
    runOp("mul_0_7",   4'd0,  4'd7,  3'b100, 8'h00, 5, 1'b0, 1'b0);
    runOp("mul_13_11", 4'd13, 4'd11, 3'b100, 8'h8F, 5, 1'b0, 1'b0);
    runOp("div_15_1",  4'd15, 4'd1,  3'b101, 8'h0F, 5, 1'b0, 1'b0);
    runOp("mod_7_9",   4'd7,  4'd9,  3'b110, 8'h07, 5, 1'b0, 1'b0);
    runOp("div_2_9",   4'd2,  4'd9,  3'b101, 8'h00, 5, 1'b0, 1'b0);
    runOp("mod_5_0",   4'd5,  4'd0,  3'b110, 8'hFF, 1, 1'b1, 1'b0);
    runOp("illegal",   4'd9,  4'd3,  3'b111, 8'h00, 1, 1'b0, 1'b1);

    // Back-pressure: result must hold and new requests must be ignored.
    out_ready = 1'b0;
    applyStimulus(4'd6, 4'd7, 3'b100, lat, rdy_seen);
    checkOutput("hold_res", {24'b0, result}, 32'h2A);
    checkOutput("hold_lat", lat, 32'd5);
    in_valid = 1'b1;
    a = 4'd1;
    b = 4'd1;
    op = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold_valid_%0d", i), {31'b0, out_valid}, 32'd1);
      checkOutput($sformatf("hold_stable_%0d", i), {24'b0, result}, 32'h2A);
      checkOutput($sformatf("hold_rdy_%0d", i), {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("hold_release", {30'b0, in_ready, out_valid}, 32'b10);
    runOp("illegal_2", 4'd4, 4'd4, 3'b111, 8'h00, 1, 1'b0, 1'b1);

    // Reset in the second BUSY cycle of a DIV aborts it.
    a = 4'd13;
    b = 4'd4;
    op = 3'b101;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_rst_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("abort_rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("abort_rst_result", {24'b0, result}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("abort_ready", {31'b0, in_ready}, 32'd1);
    ov_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      ov_seen |= out_valid;
    end
    checkOutput("abort_no_valid", {31'b0, ov_seen}, 32'd0);
    runOp("after_abort", 4'd1, 4'd2, 3'b010, 8'h03, 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
